// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result port, load issue/response ports, hazard
// queries and the register-file write port.
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_val;

    logic            ld_issue_valid;
    logic [4:0]      ld_issue_rd;

    logic            ld_rsp_valid;
    logic            ld_rsp_ready;
    logic [4:0]      ld_rsp_rd;
    logic [2:0]      ld_rsp_funct3;
    logic [1:0]      ld_rsp_addr_lo;
    logic [XLEN-1:0] ld_rsp_data;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd_query;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_busy;

    logic [4:0]      rd;
    logic            rd_write_control;
    logic [XLEN-1:0] rd_write_val;

    // valid/ready: a transfer happens in any cycle where both are high; ready
    // depends only on internal FIFO occupancy, never on valid.
    modport slave (
        input  alu_valid, alu_rd, alu_val,
        input  ld_issue_valid, ld_issue_rd,
        input  ld_rsp_valid, ld_rsp_rd, ld_rsp_funct3, ld_rsp_addr_lo, ld_rsp_data,
        input  rs1, rs2, rd_query,
        output alu_ready, ld_rsp_ready,
        output rs1_busy, rs2_busy, rd_busy,
        output rd, rd_write_control, rd_write_val
    );

    modport master (
        output alu_valid, alu_rd, alu_val,
        output ld_issue_valid, ld_issue_rd,
        output ld_rsp_valid, ld_rsp_rd, ld_rsp_funct3, ld_rsp_addr_lo, ld_rsp_data,
        output rs1, rs2, rd_query,
        input  alu_ready, ld_rsp_ready,
        input  rs1_busy, rs2_busy, rd_busy,
        input  rd, rd_write_control, rd_write_val
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and formatted load responses onto the
// single register-file write port, with a pending-load hazard scoreboard.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]      fifo_rd_q  [DEPTH];
    logic [XLEN-1:0] fifo_val_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [31:0]     pending_q, pending_d;
    logic [4:0]      rd_q;
    logic            wc_q;
    logic [XLEN-1:0] val_q;

    logic            full, empty, ld_acc, alu_acc, push, pop, sel_alu;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_fmt;
    logic [4:0]      head_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign ld_acc  = bus.ld_rsp_valid && !full;
    assign alu_acc = bus.alu_valid && !full;
    assign push    = ld_acc && (bus.ld_rsp_rd != 5'd0);
    assign head_rd = fifo_rd_q[rd_ptr_q];

    assign byte_sel = bus.ld_rsp_data[{bus.ld_rsp_addr_lo, 3'b000} +: 8];
    assign half_sel = bus.ld_rsp_addr_lo[1] ? bus.ld_rsp_data[31:16] : bus.ld_rsp_data[15:0];

    always_comb begin
        ld_fmt = bus.ld_rsp_data;
        case (bus.ld_rsp_funct3)
            3'b000:  ld_fmt = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  ld_fmt = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, half_sel};
            default: ld_fmt = bus.ld_rsp_data;
        endcase
    end

    // A full FIFO outranks the ALU so loads cannot starve behind a busy ALU.
    always_comb begin
        pop     = 1'b0;
        sel_alu = 1'b0;
        if (full && !empty) begin
            pop = 1'b1;
        end else if (alu_acc && (bus.alu_rd != 5'd0)) begin
            sel_alu = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[head_rd] = 1'b0;
        end
        if (bus.ld_issue_valid && (bus.ld_issue_rd != 5'd0)) begin
            pending_d[bus.ld_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            rd_q      <= '0;
            wc_q      <= 1'b0;
            val_q     <= '0;
        end else begin
            if (push) begin
                fifo_rd_q[wr_ptr_q]  <= bus.ld_rsp_rd;
                fifo_val_q[wr_ptr_q] <= ld_fmt;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q   <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            pending_q <= pending_d;
            wc_q      <= pop || sel_alu;
            if (pop) begin
                rd_q  <= head_rd;
                val_q <= fifo_val_q[rd_ptr_q];
            end else if (sel_alu) begin
                rd_q  <= bus.alu_rd;
                val_q <= bus.alu_val;
            end
        end
    end

    assign bus.alu_ready        = !full;
    assign bus.ld_rsp_ready     = !full;
    assign bus.rs1_busy         = pending_q[bus.rs1];
    assign bus.rs2_busy         = pending_q[bus.rs2];
    assign bus.rd_busy          = pending_q[bus.rd_query];
    assign bus.rd               = rd_q;
    assign bus.rd_write_control = wc_q;
    assign bus.rd_write_val     = val_q;
endmodule
